// File: rtl/alu_arb_pkg.sv
// Shared types and widths for the two-requester ALU arbiter.
package alu_arb_pkg;

  localparam int SEL_W = 2;
  localparam int OP_W  = 3;
  localparam int Q_W   = 4;
  localparam int ID_W  = 1;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  typedef logic [ID_W-1:0] id_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request, ALU and response signals between the arbiter and its surroundings.
// master = arbiter side, slave = front-end / ALU / result consumer side.
interface alu_arbiter_if;
  import alu_arb_pkg::*;

  logic             req0_valid;
  logic [SEL_W-1:0] req0_sel;
  logic [OP_W-1:0]  req0_a;
  logic [OP_W-1:0]  req0_b;
  logic             req0_ready;

  logic             req1_valid;
  logic [SEL_W-1:0] req1_sel;
  logic [OP_W-1:0]  req1_a;
  logic [OP_W-1:0]  req1_b;
  logic             req1_ready;

  logic [SEL_W-1:0] alu_sel;
  logic [OP_W-1:0]  alu_a;
  logic [OP_W-1:0]  alu_b;
  logic [Q_W-1:0]   alu_q;

  logic             rsp_valid;
  id_t              rsp_id;
  logic [Q_W-1:0]   rsp_q;
  logic             rsp_ready;

  modport master (
    input  req0_valid, req0_sel, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_sel, req1_a, req1_b,
    output req1_ready,
    output alu_sel, alu_a, alu_b,
    input  alu_q,
    output rsp_valid, rsp_id, rsp_q,
    input  rsp_ready
  );

  modport slave (
    output req0_valid, req0_sel, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_sel, req1_a, req1_b,
    input  req1_ready,
    input  alu_sel, alu_a, alu_b,
    output alu_q,
    input  rsp_valid, rsp_id, rsp_q,
    output rsp_ready
  );

endinterface

// File: rtl/alu_arbiter_rr_arb2.sv
// Combinational two-way picker producing a one-hot grant.
// ALU_ARB_FIXED_PRIO_EN: requester 0 always wins contention.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       prio_fixed,
  output logic [1:0] grant
);

`ifdef ALU_ARB_FIXED_PRIO_EN
  logic unused_rr_inputs;
  assign unused_rr_inputs = last ^ prio_fixed;
`endif

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01: grant = 2'b01;
      2'b10: grant = 2'b10;
      2'b11: begin
`ifdef ALU_ARB_FIXED_PRIO_EN
        grant = 2'b01;
`else
        // last names the previous winner, so the other requester goes next
        grant = (prio_fixed || last) ? 2'b01 : 2'b10;
`endif
      end
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters; registers the operands,
// waits SETTLE_CYCLES, then returns the result. Option: ALU_ARB_FIXED_PRIO_EN.
module alu_arbiter #(
  parameter int SETTLE_CYCLES = 1,
  parameter int SEL_W         = alu_arb_pkg::SEL_W,
  parameter int OP_W          = alu_arb_pkg::OP_W,
  parameter int Q_W           = alu_arb_pkg::Q_W
) (
  input logic           clk,
  input logic           rst,
  alu_arbiter_if.master bus
);
  import alu_arb_pkg::*;

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("alu_arbiter: SETTLE_CYCLES must be >= 1");
  end
  if (SEL_W != alu_arb_pkg::SEL_W || OP_W != alu_arb_pkg::OP_W ||
      Q_W != alu_arb_pkg::Q_W) begin : g_bad_width
    $error("alu_arbiter: width parameters must match alu_arb_pkg");
  end

  state_t           state, state_nxt;
  logic [SEL_W-1:0] sel_r, sel_nxt;
  logic [OP_W-1:0]  a_r, a_nxt;
  logic [OP_W-1:0]  b_r, b_nxt;
  logic             valid_r, valid_nxt;
  id_t              id_r, id_nxt;
  logic [Q_W-1:0]   q_r, q_nxt;
  logic             last_grant, last_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       grant;
  logic             ready0, ready1;

  rr_arb2 u_pick (
    .req        ({bus.req1_valid, bus.req0_valid}),
    .last       (last_grant),
    .prio_fixed (1'b0),
    .grant      (grant)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sel_r      <= '0;
      a_r        <= '0;
      b_r        <= '0;
      valid_r    <= 1'b0;
      id_r       <= '0;
      q_r        <= '0;
      last_grant <= 1'b1;
      cnt        <= '0;
    end else begin
      state      <= state_nxt;
      sel_r      <= sel_nxt;
      a_r        <= a_nxt;
      b_r        <= b_nxt;
      valid_r    <= valid_nxt;
      id_r       <= id_nxt;
      q_r        <= q_nxt;
      last_grant <= last_nxt;
      cnt        <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel_r;
    a_nxt     = a_r;
    b_nxt     = b_r;
    valid_nxt = valid_r;
    id_nxt    = id_r;
    q_nxt     = q_r;
    last_nxt  = last_grant;
    cnt_nxt   = cnt;
    ready0    = 1'b0;
    ready1    = 1'b0;
    case (state)
      IDLE: begin
        ready0 = grant[0];
        ready1 = grant[1];
        if (grant[0]) begin
          sel_nxt   = bus.req0_sel;
          a_nxt     = bus.req0_a;
          b_nxt     = bus.req0_b;
          id_nxt    = 1'b0;
          last_nxt  = 1'b0;
          cnt_nxt   = CNT_W'(SETTLE_CYCLES - 1);
          state_nxt = EXEC;
        end else if (grant[1]) begin
          sel_nxt   = bus.req1_sel;
          a_nxt     = bus.req1_a;
          b_nxt     = bus.req1_b;
          id_nxt    = 1'b1;
          last_nxt  = 1'b1;
          cnt_nxt   = CNT_W'(SETTLE_CYCLES - 1);
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        // ALU inputs have been stable for SETTLE_CYCLES once the count runs out
        if (cnt == '0) begin
          q_nxt     = bus.alu_q;
          valid_nxt = 1'b1;
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          valid_nxt = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.alu_sel    = sel_r;
  assign bus.alu_a      = a_r;
  assign bus.alu_b      = b_r;
  assign bus.rsp_valid  = valid_r;
  assign bus.rsp_id     = id_r;
  assign bus.rsp_q      = q_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: one instance with SETTLE_CYCLES=1, one with 3,
// each driving a behavioural ALU stub. Honours ALU_ARB_FIXED_PRIO_EN if defined.
module tb_alu_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic forceBad = 1'b0;
  int   checkCount = 0;
  int   passCount = 0;
  int   cycle = 0;
  int   lastAccept = 0;

  alu_arbiter_if b1 ();
  alu_arbiter_if b3 ();

  alu_arbiter #(.SETTLE_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  alu_arbiter #(.SETTLE_CYCLES(3)) dut3 (.clk(clk), .rst(rst), .bus(b3));

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  function automatic logic [3:0] aluModel(input logic [1:0] sel, input logic [2:0] a,
                                          input logic [2:0] b);
    if (sel == 2'b00) return {1'b0, a} + {1'b0, b};
    return {1'b0, a ^ b};
  endfunction

  assign b1.alu_q = aluModel(b1.alu_sel, b1.alu_a, b1.alu_b);
  assign b3.alu_q = forceBad ? 4'hF : aluModel(b3.alu_sel, b3.alu_a, b3.alu_b);

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic applyStimulus(input logic v0, input logic [1:0] s0, input logic [2:0] a0,
                               input logic [2:0] bb0, input logic v1, input logic [1:0] s1,
                               input logic [2:0] a1, input logic [2:0] bb1);
    b1.req0_valid = v0; b1.req0_sel = s0; b1.req0_a = a0; b1.req0_b = bb0;
    b1.req1_valid = v1; b1.req1_sel = s1; b1.req1_a = a1; b1.req1_b = bb1;
  endtask

  // One full transaction on the SETTLE_CYCLES=1 instance, with bounded waits.
  task automatic runTxn(input string tag, input int expId, input logic [3:0] expQ,
                        input bit checkGap);
    int n;
    n = 0;
    #1;
    while (!(b1.req0_ready || b1.req1_ready) && n < 20) begin
      tick(); #1; n++;
    end
    checkOutput({tag, " ready0"}, b1.req0_ready, expId == 0);
    checkOutput({tag, " ready1"}, b1.req1_ready, expId == 1);
    tick();
    if (checkGap) checkOutput({tag, " issue gap"}, cycle - lastAccept, 3);
    lastAccept = cycle;
    n = 0;
    while (!b1.rsp_valid && n < 20) begin
      tick(); n++;
    end
    checkOutput({tag, " rsp_valid"}, b1.rsp_valid, 1);
    checkOutput({tag, " rsp_id"}, b1.rsp_id, expId);
    checkOutput({tag, " rsp_q"}, b1.rsp_q, expQ);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int ids6 [4];
    logic [3:0] qs6 [4];
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    b1.rsp_ready = 1'b1;
    b3.req0_valid = 0; b3.req0_sel = 0; b3.req0_a = 0; b3.req0_b = 0;
    b3.req1_valid = 0; b3.req1_sel = 0; b3.req1_a = 0; b3.req1_b = 0;
    b3.rsp_ready = 1'b1;
    tick();
    doReset();

    // Reset state
    checkOutput("reset rsp_valid", b1.rsp_valid, 0);
    checkOutput("reset rsp_id", b1.rsp_id, 0);
    checkOutput("reset rsp_q", b1.rsp_q, 0);
    checkOutput("reset alu", {b1.alu_sel, b1.alu_a, b1.alu_b}, 0);
    checkOutput("reset ready", {b1.req1_ready, b1.req0_ready}, 0);

    // Test 1: single request, 5+6
    applyStimulus(1, 2'b00, 3'd5, 3'd6, 0, 0, 0, 0);
    #1;
    checkOutput("t1 ready0", b1.req0_ready, 1);
    checkOutput("t1 ready1", b1.req1_ready, 0);
    tick();
    checkOutput("t1 alu", {b1.alu_sel, b1.alu_a, b1.alu_b}, {2'b00, 3'd5, 3'd6});
    checkOutput("t1 exec rsp_valid", b1.rsp_valid, 0);
    checkOutput("t1 exec ready0", b1.req0_ready, 0);
    b1.req0_valid = 1'b0;
    tick();
    checkOutput("t1 rsp_valid", b1.rsp_valid, 1);
    checkOutput("t1 rsp_id", b1.rsp_id, 0);
    checkOutput("t1 rsp_q", b1.rsp_q, 11);
    tick();
    checkOutput("t1 rsp consumed", b1.rsp_valid, 0);

    // Test 2: continuous contention alternates
    doReset();
    applyStimulus(1, 2'b00, 3'd1, 3'd1, 1, 2'b00, 3'd2, 3'd2);
    runTxn("t2 txn0", 0, 4'd2, 0);
    runTxn("t2 txn1", 1, 4'd4, 1);
    runTxn("t2 txn2", 0, 4'd2, 1);
    runTxn("t2 txn3", 1, 4'd4, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // Test 3: back-pressure holds the response
    doReset();
    b1.rsp_ready = 1'b0;
    applyStimulus(1, 2'b01, 3'd3, 3'd5, 0, 0, 0, 0);
    #1;
    checkOutput("t3 ready0", b1.req0_ready, 1);
    tick();
    applyStimulus(0, 2'b00, 3'd7, 3'd7, 1, 2'b00, 3'd1, 3'd1);
    tick();
    for (int i = 0; i < 5; i++) begin
      checkOutput("t3 hold rsp_valid", b1.rsp_valid, 1);
      checkOutput("t3 hold rsp_q", b1.rsp_q, 6);
      checkOutput("t3 hold rsp_id", b1.rsp_id, 0);
      checkOutput("t3 hold readies", {b1.req1_ready, b1.req0_ready}, 0);
      checkOutput("t3 hold alu", {b1.alu_sel, b1.alu_a, b1.alu_b}, {2'b01, 3'd3, 3'd5});
      tick();
    end
    b1.rsp_ready = 1'b1;
    tick();
    checkOutput("t3 released rsp_valid", b1.rsp_valid, 0);
    #1;
    checkOutput("t3 next ready1", b1.req1_ready, 1);
    tick();
    b1.req1_valid = 1'b0;
    tick();
    checkOutput("t3 req1 rsp_id", b1.rsp_id, 1);
    checkOutput("t3 req1 rsp_q", b1.rsp_q, 2);
    tick();

    // Test 4: SETTLE_CYCLES=3, early ALU output is garbage
    doReset();
    forceBad = 1'b1;
    b3.req1_valid = 1'b1; b3.req1_sel = 2'b01; b3.req1_a = 3'd7; b3.req1_b = 3'd2;
    #1;
    checkOutput("t4 ready1", b3.req1_ready, 1);
    checkOutput("t4 ready0", b3.req0_ready, 0);
    tick();
    b3.req1_valid = 1'b0; b3.req1_a = 3'd0;
    for (int i = 0; i < 3; i++) begin
      checkOutput("t4 alu held", {b3.alu_sel, b3.alu_a, b3.alu_b}, {2'b01, 3'd7, 3'd2});
      checkOutput("t4 no early rsp", b3.rsp_valid, 0);
      if (i == 1) forceBad = 1'b0;
      tick();
    end
    checkOutput("t4 rsp_valid", b3.rsp_valid, 1);
    checkOutput("t4 rsp_q", b3.rsp_q, 5);
    checkOutput("t4 rsp_id", b3.rsp_id, 1);
    tick();
    checkOutput("t4 rsp consumed", b3.rsp_valid, 0);

    // Test 5: reset during EXEC discards the transaction
    doReset();
    applyStimulus(1, 2'b00, 3'd3, 3'd4, 0, 0, 0, 0);
    tick();
    rst = 1'b1;
    b1.req0_valid = 1'b0;
    tick();
    rst = 1'b0;
    checkOutput("t5 rsp_valid", b1.rsp_valid, 0);
    checkOutput("t5 rsp_q", b1.rsp_q, 0);
    checkOutput("t5 alu", {b1.alu_sel, b1.alu_a, b1.alu_b}, 0);
    tick();
    checkOutput("t5 still no rsp", b1.rsp_valid, 0);
    applyStimulus(1, 2'b00, 3'd1, 3'd2, 1, 2'b00, 3'd3, 3'd3);
    runTxn("t5 txn0", 0, 4'd3, 0);
    runTxn("t5 txn1", 1, 4'd6, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // Test 6: contention policy over four transactions
    doReset();
`ifdef ALU_ARB_FIXED_PRIO_EN
    ids6 = '{0, 0, 0, 0};
    qs6  = '{4'd7, 4'd7, 4'd7, 4'd7};
`else
    ids6 = '{0, 1, 0, 1};
    qs6  = '{4'd7, 4'd0, 4'd7, 4'd0};
`endif
    applyStimulus(1, 2'b01, 3'd6, 3'd1, 1, 2'b01, 3'd4, 3'd4);
    for (int i = 0; i < 4; i++) runTxn("t6 txn", ids6[i], qs6[i], i != 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares the single combinational ALU (2-bit select, two 3-bit operands, 4-bit result) between two requesters.
- Arbitrates round-robin between the two requesters.
- Registers the winning operation onto the ALU inputs and holds it for a programmable settle time.
- Samples the result and returns it on a valid/ready response channel tagged with the requester id.
- Sits between the switch/button front-end logic and the ALU instance in the top level.

Parameters:
- SETTLE_CYCLES, 1, cycles ALU inputs are held before q is sampled; must be >=1, and 0 is an elaboration error.
- SEL_W, 2, ALU select width.
- OP_W, 3, ALU operand width.
- Q_W, 4, ALU result width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_sel  in  SEL_W  requester 0 ALU select.
- req0_a  in  OP_W  requester 0 operand a.
- req0_b  in  OP_W  requester 0 operand b.
- req0_ready  out  1  requester 0 accepted this cycle.
- req1_valid, req1_sel, req1_a, req1_b, req1_ready: same as requester 0.
- alu_sel  out  SEL_W  drives ALU swSelect (registered).
- alu_a  out  OP_W  drives ALU a (registered).
- alu_b  out  OP_W  drives ALU b (registered).
- alu_q  in  Q_W  ALU result.
- rsp_valid  out  1  result available.
- rsp_id  out  1  requester that owns the result.
- rsp_q  out  Q_W  captured ALU result.
- rsp_ready  in  1  consumer takes the result.

Behaviour:
- Clock and reset: one clock, clk; rst is synchronous and active-high. All state changes on the rising edge of clk.
- Reset values: state=IDLE; alu_sel/alu_a/alu_b=0; rsp_valid=0; rsp_id=0; rsp_q=0; last_grant=1, so requester 0 wins the first contention; settle counter=0.
- States: IDLE, EXEC, RESP.
- IDLE, grant selection:
  - If exactly one reqN_valid is high, grant it.
  - If both are high, grant the requester != last_grant.
  - reqN_ready = (state==IDLE) & grant==N. It is combinational from valid and never high for both requesters.
- IDLE, on accept (valid & ready):
  - Register sel/a/b onto alu_*.
  - Latch rsp_id=N and last_grant=N.
  - Load counter=SETTLE_CYCLES-1; go to EXEC.
- IDLE, no valid: stay in IDLE; alu_* hold their previous values (no toggling while idle).
- EXEC:
  - alu_* held constant.
  - If counter==0: rsp_q<=alu_q, rsp_valid<=1, go to RESP.
  - Else: decrement counter.
- RESP:
  - rsp_valid, rsp_id and rsp_q held stable until rsp_ready.
  - On rsp_valid & rsp_ready: rsp_valid<=0, go to IDLE.
  - Both reqN_ready stay 0 throughout RESP.
- Latency: accept at edge T, rsp_valid visible after edge T+SETTLE_CYCLES. Minimum issue interval is SETTLE_CYCLES+2 cycles with rsp_ready tied high.
- Width rule: rsp_q is alu_q passed through unmodified; no extension or truncation.
- Request inputs may change after accept without affecting the in-flight operation.
- A requester dropping valid before it is granted is legal; it simply loses its turn.
- Reset mid-operation: the in-flight transaction is discarded, no response is issued, and last_grant returns to 1.
- rsp_ready high while not in RESP: ignored.

Optional Feature:
- Macro: ALU_ARB_FIXED_PRIO_EN.
- Defined: requester 0 always wins when both are valid. last_grant is not used for selection but is still updated, so rsp_id is unchanged in meaning.
- Undefined (default): round-robin as specified above.

Decomposition:
- Package alu_arb_pkg:
  - state enum {IDLE, EXEC, RESP};
  - localparams SEL_W=2, OP_W=3, Q_W=4;
  - ID constant width 1.
- Sub-module rr_arb2:
  - Purely combinational two-way picker.
  - Inputs: req[1:0], last, prio_fixed.
  - Output: one-hot grant[1:0].
  - The fixed-priority macro is applied at this sub-module only.

Test Plan:
ALU stub for the bench: q = {1'b0,a} + {1'b0,b} when sel=00, otherwise q = {1'b0, a^b}.
1. Reset, then req0 {sel=00,a=5,b=6}, SETTLE_CYCLES=1, rsp_ready=1 -> req0_ready high in the first IDLE cycle; rsp_valid 2 edges later with rsp_id=0, rsp_q=11.
2. Both requesters valid continuously, req0 a=1,b=1 and req1 a=2,b=2, sel=00 -> grants alternate 0,1,0,1; responses 2,4,2,4 with matching rsp_id.
3. rsp_ready low for 5 cycles in RESP -> rsp_valid/rsp_q/rsp_id stable; no reqN_ready; alu_* unchanged.
4. SETTLE_CYCLES=3, req1 {sel=01,a=7,b=2}; alu_q forced to X until 2 cycles after issue -> rsp_q=5; alu_* constant for 3 cycles.
5. rst asserted during EXEC -> next cycle: IDLE, outputs at reset values, no rsp_valid; then both valid -> req0 granted first.
6. With ALU_ARB_FIXED_PRIO_EN defined, both valid for 4 transactions -> every grant goes to requester 0; req1 is never granted while req0 stays valid.
